// File: rtl/cdb_rr_arbiter.sv
// Round-robin arbiter for the common data bus: picks at most one pending
// functional-unit result per cycle and registers it as the CDB broadcast.
module cdb_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src
);

    localparam logic [SRC_W:0]   N_EXT = (SRC_W+1)'(N_REQ);
    localparam logic [SRC_W-1:0] LAST  = SRC_W'(N_REQ - 1);

    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W:0]    cand;
    logic [SRC_W-1:0]  gidx;
    logic              found;
    logic              grant;
    logic [SRC_W-1:0]  ptr_next;
    logic [TAG_W-1:0]  grant_tag;
    logic [DATA_W-1:0] grant_data;

    // Circular search starting at rr_ptr; the first valid hit wins.
    always_comb begin
        cand  = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (cand >= N_EXT)
                cand = cand - N_EXT;
            if (!found && req_valid[cand[SRC_W-1:0]]) begin
                found = 1'b1;
                gidx  = cand[SRC_W-1:0];
            end
        end
    end

    assign grant = found && !flush && rstn;

    always_comb begin
        req_ready = '0;
        if (grant)
            req_ready[gidx] = 1'b1;
    end

    assign ptr_next   = (gidx == LAST) ? '0 : gidx + 1'b1;
    assign grant_tag  = req_tag[int'(gidx)*TAG_W +: TAG_W];
    assign grant_data = req_data[int'(gidx)*DATA_W +: DATA_W];

    // Broadcast register; tag/data/src keep their last values on idle cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= grant_tag;
            cdb_data  <= grant_data;
            cdb_src   <= gidx;
            rr_ptr    <= ptr_next;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed bench for cdb_rr_arbiter: N_REQ=4, fixed per-FU tags/data,
// hand-computed grants and broadcasts checked with immediate assertions.
module tb_cdb_rr_arbiter;

    localparam int N_REQ  = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    logic                     clk;
    logic                     rstn;
    logic                     flush;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*TAG_W-1:0]   req_tag;
    logic [N_REQ*DATA_W-1:0]  req_data;
    logic [N_REQ-1:0]         req_ready;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic [1:0]               cdb_src;

    int total = 0;
    int bad   = 0;

    logic [TAG_W-1:0]  tag_tbl  [N_REQ];
    logic [DATA_W-1:0] data_tbl [N_REQ];

    cdb_rr_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol invariants sampled mid-cycle, away from the active edge.
    logic prev_any;
    logic have_prev;
    always @(negedge rstn) have_prev = 1'b0;
    always @(negedge clk) begin
        if (rstn) begin
            chk("inv_onehot", 64'($onehot0(req_ready)), 64'd1);
            chk("inv_ready_implies_valid", 64'(req_ready & ~req_valid), 64'd0);
            if (flush)
                chk("inv_no_grant_on_flush", 64'(req_ready), 64'd0);
            if (have_prev)
                chk("inv_cdb_valid_follows_grant", 64'(cdb_valid), 64'(prev_any));
            prev_any  = |req_ready;
            have_prev = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tag_tbl[0] = 6'h0A; data_tbl[0] = 32'h0000_000A;
        tag_tbl[1] = 6'h21; data_tbl[1] = 32'h1111_1111;
        tag_tbl[2] = 6'h15; data_tbl[2] = 32'hDEAD_BEEF;
        tag_tbl[3] = 6'h33; data_tbl[3] = 32'h3333_3333;
        for (int i = 0; i < N_REQ; i++) begin
            req_tag[i*TAG_W +: TAG_W]    = tag_tbl[i];
            req_data[i*DATA_W +: DATA_W] = data_tbl[i];
        end
        have_prev = 1'b0;
        prev_any  = 1'b0;
        rstn      = 1'b0;
        flush     = 1'b0;
        req_valid = 4'b1111;

        // Reset: outputs cleared, no grant even with requests pending.
        #3;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("rst_cdb_src", 64'(cdb_src), 64'h0);
        chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'h0);
        req_valid = 4'b0000;
        #9 rstn = 1'b1;

        // Idle.
        tick();
        chk("idle_ready", 64'(req_ready), 64'h0);
        chk("idle_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("idle_rr_ptr", 64'(dut.rr_ptr), 64'h0);

        // Single request on FU2.
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = 4'b0000;
        chk("single_cdb_valid", 64'(cdb_valid), 64'h1);
        chk("single_cdb_tag", 64'(cdb_tag), 64'h15);
        chk("single_cdb_data", 64'(cdb_data), 64'hDEADBEEF);
        chk("single_cdb_src", 64'(cdb_src), 64'h2);
        chk("single_rr_ptr", 64'(dut.rr_ptr), 64'h3);

        // Wrap from rr_ptr=3 with FU3 and FU0 pending.
        req_valid = 4'b1001;
        #1;
        chk("wrap_ready_a", 64'(req_ready), 64'h8);
        tick();
        req_valid = 4'b0001;
        chk("wrap_src_a", 64'(cdb_src), 64'h3);
        chk("wrap_tag_a", 64'(cdb_tag), 64'h33);
        chk("wrap_ready_b", 64'(req_ready), 64'h1);
        tick();
        req_valid = 4'b0000;
        chk("wrap_src_b", 64'(cdb_src), 64'h0);
        chk("wrap_valid_b", 64'(cdb_valid), 64'h1);
        chk("wrap_rr_ptr", 64'(dut.rr_ptr), 64'h1);
        tick();
        chk("wrap_idle_valid", 64'(cdb_valid), 64'h0);
        chk("wrap_idle_tag_hold", 64'(cdb_tag), 64'h0A);

        // Grant FU1, then flush while that broadcast is on the bus.
        req_valid = 4'b1111;
        #1;
        chk("preflush_ready", 64'(req_ready), 64'h2);
        tick();
        flush = 1'b1;
        #1;
        chk("flush_ready", 64'(req_ready), 64'h0);
        chk("flush_cdb_still_valid", 64'(cdb_valid), 64'h1);
        chk("flush_cdb_src", 64'(cdb_src), 64'h1);
        tick();
        chk("postflush_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("postflush_src_hold", 64'(cdb_src), 64'h1);
        chk("postflush_rr_ptr", 64'(dut.rr_ptr), 64'h2);
        flush = 1'b0;
        #1;
        chk("resume_ready", 64'(req_ready), 64'h4);
        tick();
        chk("resume_cdb_src", 64'(cdb_src), 64'h2);
        chk("resume_cdb_valid", 64'(cdb_valid), 64'h1);
        chk("resume_rr_ptr", 64'(dut.rr_ptr), 64'h3);

        // Async reset mid-cycle while cdb_valid=1.
        #2 rstn = 1'b0;
        #1;
        chk("arst_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("arst_cdb_tag", 64'(cdb_tag), 64'h0);
        chk("arst_cdb_data", 64'(cdb_data), 64'h0);
        chk("arst_rr_ptr", 64'(dut.rr_ptr), 64'h0);
        chk("arst_ready", 64'(req_ready), 64'h0);
        #1 rstn = 1'b1;

        // All four held valid: grants 0,1,2,3,0,1,2,3 back to back.
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            chk($sformatf("rr_cdb_valid_%0d", k), 64'(cdb_valid), 64'h1);
            chk($sformatf("rr_cdb_src_%0d", k), 64'(cdb_src), 64'(k % 4));
            chk($sformatf("rr_cdb_tag_%0d", k), 64'(cdb_tag), 64'(tag_tbl[k % 4]));
        end
        req_valid = 4'b0000;
        tick();
        chk("end_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("end_rr_ptr", 64'(dut.rr_ptr), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
